// File: rtl/llr_pkg.sv
// Shared constants for the latch-last-read output stage.
package llr_pkg;

    localparam int LLR_WIDTH_DEFAULT = 8;

endpackage : llr_pkg

// File: rtl/llr_hold_reg_sync_dff.sv
// Plain register with synchronous active-high clear and an optional load enable.
module sync_dff #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_o <= '0;
        end else if (en_i) begin
            data_o <= data_i;
        end
    end

endmodule : sync_dff

// File: rtl/llr_hold_reg.sv
// Latch-last-read stage: bypasses RAM read data while it is valid, otherwise
// holds the last valid word.
module llr_hold_reg
    import llr_pkg::*;
#(
    parameter int width_p    = LLR_WIDTH_DEFAULT,
    parameter bit delay_en_p = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic               en_eff;
    logic [width_p-1:0] data_r;

    // With delay_en_p=1, en_i is a read request and the data arrives a cycle
    // later, so only the registered copy may steer the output mux.
    if (delay_en_p) begin : g_en_delay
        logic en_r;

        sync_dff #(.width_p(1)) en_reg (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .en_i    (1'b1),
            .data_i  (en_i),
            .data_o  (en_r)
        );

        assign en_eff = en_r;
    end else begin : g_en_direct
        assign en_eff = en_i;
    end

    sync_dff #(.width_p(width_p)) data_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (en_eff),
        .data_i  (data_i),
        .data_o  (data_r)
    );

    // Reset deliberately does not gate the bypass path.
    assign data_o = en_eff ? data_i : data_r;

endmodule : llr_hold_reg

// File: tb/tb_llr_hold_reg.sv
// Bench for llr_hold_reg: delayed/undelayed enable and width 1/8/64 variants
// driven from shared stimulus, checked against a per-cycle expected queue.
module tb_llr_hold_reg;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        en_i = 1'b0;
    logic [63:0] data_bus = 64'hA5;

    logic [7:0]  out8;
    logic [7:0]  out0;
    logic [0:0]  out1;
    logic [63:0] out64;

    logic [63:0] exp_q[$];
    logic [63:0] exp_v;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    llr_hold_reg #(.width_p(8), .delay_en_p(1'b1)) dut8 (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .data_i(data_bus[7:0]), .data_o(out8)
    );
    llr_hold_reg #(.width_p(8), .delay_en_p(1'b0)) dut0 (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .data_i(data_bus[7:0]), .data_o(out0)
    );
    llr_hold_reg #(.width_p(1), .delay_en_p(1'b1)) dut1 (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .data_i(data_bus[0:0]), .data_o(out1)
    );
    llr_hold_reg #(.width_p(64), .delay_en_p(1'b1)) dut64 (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .data_i(data_bus), .data_o(out64)
    );

    // Inputs change just after the active edge; outputs are sampled on the negedge.
    task automatic drive(input logic rst, input logic en, input logic [63:0] d);
        @(posedge clk);
        #1;
        reset_i  = rst;
        en_i     = en;
        data_bus = d;
    endtask

    task automatic test_reset();
        logic [7:0] rst_seq[5] = '{1, 1, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            drive(rst_seq[i][0], 1'b0, 64'hA5);
            exp_q.push_back(64'h0);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (out8 !== exp_v[7:0]) begin
                $display("FAIL reset_d8 cyc%0d: got %h want %h", i, out8, exp_v[7:0]);
                n_fail++;
            end
            n_tests++;
            if (out0 !== exp_v[7:0]) begin
                $display("FAIL reset_d0 cyc%0d: got %h want %h", i, out0, exp_v[7:0]);
                n_fail++;
            end
        end
    endtask

    task automatic test_single_read();
        logic        en_seq[4] = '{1, 0, 0, 0};
        logic [7:0]  d_seq[4]  = '{8'hC3, 8'h3C, 8'hFF, 8'h00};
        logic [7:0]  e_seq[4]  = '{8'h00, 8'h3C, 8'h3C, 8'h3C};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, en_seq[i], {56'h0, d_seq[i]});
            exp_q.push_back({56'h0, e_seq[i]});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (out8 !== exp_v[7:0]) begin
                $display("FAIL single_read cyc%0d: got %h want %h", i, out8, exp_v[7:0]);
                n_fail++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        en_seq[6] = '{1, 1, 1, 0, 0, 0};
        logic [7:0]  d_seq[6]  = '{8'h99, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        logic [7:0]  e_seq[6]  = '{8'h3C, 8'h11, 8'h22, 8'h33, 8'h33, 8'h33};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, en_seq[i], {56'h0, d_seq[i]});
            exp_q.push_back({56'h0, e_seq[i]});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (out8 !== exp_v[7:0]) begin
                $display("FAIL back_to_back cyc%0d: got %h want %h", i, out8, exp_v[7:0]);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic        rst_seq[6] = '{0, 0, 0, 1, 0, 0};
        logic        en_seq[6]  = '{1, 0, 0, 1, 0, 0};
        logic [7:0]  d_seq[6]   = '{8'h00, 8'h5A, 8'h00, 8'hEE, 8'hBB, 8'hCC};
        logic [7:0]  e_seq[6]   = '{8'h33, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            drive(rst_seq[i], en_seq[i], {56'h0, d_seq[i]});
            exp_q.push_back({56'h0, e_seq[i]});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (out8 !== exp_v[7:0]) begin
                $display("FAIL reset_mid_hold cyc%0d: got %h want %h", i, out8, exp_v[7:0]);
                n_fail++;
            end
        end
    endtask

    task automatic test_no_delay();
        logic        rst_seq[4] = '{0, 0, 1, 0};
        logic        en_seq[4]  = '{1, 0, 1, 0};
        logic [7:0]  d_seq[4]   = '{8'h77, 8'h00, 8'h42, 8'h11};
        logic [7:0]  e_seq[4]   = '{8'h77, 8'h77, 8'h42, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(rst_seq[i], en_seq[i], {56'h0, d_seq[i]});
            exp_q.push_back({56'h0, e_seq[i]});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (out0 !== exp_v[7:0]) begin
                $display("FAIL no_delay cyc%0d: got %h want %h", i, out0, exp_v[7:0]);
                n_fail++;
            end
        end
    endtask

    task automatic test_widths();
        logic        rst_seq[5] = '{1, 0, 0, 0, 0};
        logic        en_seq[5]  = '{0, 1, 0, 0, 0};
        logic [63:0] d_seq[5];
        logic [63:0] e_seq[5];
        d_seq = '{64'h0, 64'h0, '1, 64'h0, 64'h0};
        e_seq = '{64'h0, 64'h0, '1, '1, '1};
        for (int i = 0; i < 5; i++) begin
            drive(rst_seq[i], en_seq[i], d_seq[i]);
            exp_q.push_back(e_seq[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (out1 !== exp_v[0:0]) begin
                $display("FAIL width1 cyc%0d: got %b want %b", i, out1, exp_v[0:0]);
                n_fail++;
            end
            n_tests++;
            if (out64 !== exp_v) begin
                $display("FAIL width64 cyc%0d: got %h want %h", i, out64, exp_v);
                n_fail++;
            end
        end
    endtask

    task automatic test_random();
        logic       m_en_r = 1'b0;
        logic [7:0] m_data_r = 8'h00;
        logic       en;
        logic [7:0] d;
        drive(1'b1, 1'b0, 64'h0);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            en = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            drive(1'b0, en, {56'h0, d});
            // Reference behaviour: output from the pre-edge state, then advance it.
            exp_q.push_back({56'h0, (m_en_r ? d : m_data_r)});
            if (m_en_r) m_data_r = d;
            m_en_r = en;
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_tests++;
            if (out8 !== exp_v[7:0]) begin
                $display("FAIL random cyc%0d: got %h want %h", i, out8, exp_v[7:0]);
                n_fail++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_reset_mid_hold();
        test_no_delay();
        test_widths();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_llr_hold_reg
